// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Reset is asynchronous and active-low; RST_ASSERT is the asserted level.
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t ZERO_WORD   = '0;
  localparam int    FETCH_DEPTH = 2;
  localparam logic  RST_ASSERT  = 1'b0;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_word_t;

  function automatic inst_addr_t next_pc(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Two-entry FIFO with simultaneous push/pop, synchronous clear and occupancy count.
// Used both as the in-flight address queue and as the returned-instruction buffer.
module if_stage_fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The fetch credit scheme must make these unreachable.
  overflow_chk: assert property (@(posedge clk) disable iff (rst == RST_ASSERT)
    !(push_i && !pop_i && !clr_i && count_q == 2'd2));
  underflow_chk: assert property (@(posedge clk) disable iff (rst == RST_ASSERT)
    !(pop_i && !clr_i && count_q == 2'd0));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order fetches,
// buffers returning words and drives the IF/ID register with stall and flush.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter int         DEPTH    = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] redirect_pc_i,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INST_W-1:0]      imem_rdata_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  inst_addr_t  fetch_pc_q, fetch_pc_d;
  logic [1:0]  discard_q, discard_d;
  inst_addr_t  pc_q, pc_d;
  inst_t       inst_q, inst_d;

  logic [1:0]  outst;
  logic [1:0]  bcnt;
  inst_addr_t  aq_head;
  fetch_word_t ib_head;
  fetch_word_t rsp_word;
  logic [2:0]  credits;
  logic        fire;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        ib_push;
  logic        ib_pop;

  // Stale responses still count against credit until they drain.
  assign credits    = {1'b0, outst} + {1'b0, bcnt};
  assign imem_req_o = (rst != RST_ASSERT) && !flush_i && (credits < DEPTH_L);
  assign imem_addr_o = fetch_pc_q;
  assign fire       = imem_req_o && imem_gnt_i;

  assign rsp_drop = imem_rvalid_i && (discard_q != 2'd0);
  assign rsp_keep = imem_rvalid_i && (discard_q == 2'd0) && !flush_i;
  assign rsp_word = {aq_head, imem_rdata_i};
  assign ib_push  = rsp_keep && (stall_i || bcnt != 2'd0);
  assign ib_pop   = !flush_i && !stall_i && (bcnt != 2'd0);

  if_stage_fetch_fifo #(.W(INST_ADDR_W)) u_addr_q (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (1'b0),
    .push_i      (fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (imem_rvalid_i),
    .head_o      (aq_head),
    .count_o     (outst)
  );

  if_stage_fetch_fifo #(.W($bits(fetch_word_t))) u_inst_buf (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush_i),
    .push_i      (ib_push),
    .push_data_i (rsp_word),
    .pop_i       (ib_pop),
    .head_o      (ib_head),
    .count_o     (bcnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (flush_i) begin
      fetch_pc_d = redirect_pc_i;
      // The address queue is kept, so every request still in flight becomes a discard.
      discard_d  = outst - {1'b0, imem_rvalid_i};
    end else begin
      if (fire) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end
      if (rsp_drop) begin
        discard_d = discard_q - 2'd1;
      end
    end
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    if (flush_i) begin
      pc_d   = ZERO_WORD;
      inst_d = ZERO_WORD;
    end else if (!stall_i) begin
      if (bcnt != 2'd0) begin
        pc_d   = ib_head.pc;
        inst_d = ib_head.inst;
      end else if (rsp_keep) begin
        pc_d   = aq_head;
        inst_d = imem_rdata_i;
      end else begin
        pc_d   = ZERO_WORD;
        inst_d = ZERO_WORD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= 2'd0;
      pc_q       <= ZERO_WORD;
      inst_q     <= ZERO_WORD;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a memory model answers grants in
// order and every kept grant is expected to retire through IF/ID exactly once.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  mem_req_t    pending[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          last_due = -1;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;
  logic [31:0] mon_exp;
  logic [31:0] a0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // One cycle: drive inputs just after negedge, check combinational outputs, update model.
  task automatic step(input bit st, input bit fl, input logic [31:0] rpc, input bit g);
    int stale;
    bit m_req;
    int due;
    stale = 0;
    foreach (pending[i]) if (pending[i].epoch != epoch) stale++;
    m_req = !fl && (stale + exp_q.size() < DEPTH);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end
    stall_i       = st;
    flush_i       = fl;
    redirect_pc_i = rpc;
    imem_gnt_i    = g;
    #1;
    check("req", 32'(imem_req_o), 32'(m_req));
    check("addr", imem_addr_o, model_pc);
    if (fl) begin
      exp_q.delete();
      epoch++;
      model_pc = rpc;
    end else if (m_req && g) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      pending.push_back('{model_pc, due, epoch});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst           = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    pending.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    last_due = -1;
    #1;
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_addr", imem_addr_o, RESET_PC);
    repeat (hold) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  task automatic run_until(input logic [31:0] target, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (inst_o != 32'h0) begin
        found = 1'b1;
        check(name, pc_o, target);
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no instruction within 30 cycles, required pc %h", name, target);
    end
  endtask

  // Monitor: retires each newly loaded IF/ID entry against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_hold_pc", pc_o, 32'h0);
      check("rst_hold_inst", inst_o, 32'h0);
    end else if (flush_i) begin
      check("flush_pc", pc_o, 32'h0);
      check("flush_inst", inst_o, 32'h0);
    end else if (stall_i) begin
      check("hold_pc", pc_o, last_pc);
      check("hold_inst", inst_o, last_inst);
    end else if (inst_o != 32'h0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL retire: got pc %h inst %h, required none pending", pc_o, inst_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("retire_pc", pc_o, mon_exp);
        check("retire_inst", inst_o, mem_word(mon_exp));
        $display("retire pc=%h inst=%h", pc_o, inst_o);
      end
    end else begin
      check("bubble_pc", pc_o, 32'h0);
    end
    last_pc   = pc_o;
    last_inst = inst_o;
  end

  initial begin
    #1;
    do_reset(3);

    // Reset release with a 1-cycle memory.
    lat = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("first_pc", pc_o, RESET_PC);
    check("first_inst", inst_o, mem_word(RESET_PC));
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("second_pc", pc_o, RESET_PC + 32'd4);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Four-cycle stall mid-stream.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stall_req_drop", 32'(imem_req_o), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with requests outstanding on a 3-cycle memory.
    lat = 3;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    run_until(32'h100, "flush_target");
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Flush coincident with a response while stalled.
    lat = 1;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    check("flush_stall_bubble", inst_o, 32'h0);
    run_until(32'h200, "flush_stall_target");

    // Grant withheld for five cycles.
    a0 = model_pc;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("gnt_hold_addr", imem_addr_o, a0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           32'($urandom_range(0, 1023)) << 2, $urandom_range(0, 9) < 7);
    end

    // Reset while the buffer holds two words.
    lat = 1;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("pre_rst_req", 32'(imem_req_o), 32'h0);
    do_reset(2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("restart_pc", pc_o, RESET_PC);
    check("restart_inst", inst_o, mem_word(RESET_PC));
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Drain: everything granted must have retired.
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("drain_expected", 32'(exp_q.size()), 32'h0);
    check("drain_pending", 32'(pending.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
